// File: rtl/ixc_assign_sched_if.sv
// Request/consumer bundle for ixc_assign_sched.
// The slave modport is the scheduler side. The master modport is the requester/consumer side.
interface ixc_assign_sched_if #(
  parameter int WIDTH = 29,
  parameter int NREQ  = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_data, out_valid, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_data, out_valid, grant_id, busy
  );
endinterface

// File: rtl/ixc_assign_sched.sv
// Round-robin scheduler for a shared static assign path. out_data is the hold register
// that feeds the R input of the shared assign cell, and it keeps its word until the next acceptance.
module ixc_assign_sched #(
  parameter int WIDTH = 29,
  parameter int NREQ  = 4,
  parameter int HOLD  = 2
) (
  input logic clk,
  input logic rst,
  ixc_assign_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]    grant_reg, grant_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [WIDTH-1:0] data_reg, data_next;

  logic [NREQ-1:0]  hi_mask;
  logic [NREQ-1:0]  hi_req;
  logic [NREQ-1:0]  ready_vec;
  logic [IW-1:0]    winner;
  logic             any_req;

  // hi_mask selects requesters at or above rr_ptr. Those win before the search wraps to index 0.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign hi_mask[gi]   = (IW'(gi) >= rr_ptr_reg);
    assign ready_vec[gi] = (state_reg == IDLE) && any_req && (winner == IW'(gi));
  end

  assign hi_req  = bus.req_valid & hi_mask;
  assign any_req = |bus.req_valid;

  always_comb begin
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) winner = IW'(k);
    end
    if (|hi_req) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (hi_req[k]) winner = IW'(k);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    cnt_next    = cnt_reg;
    data_next   = data_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          data_next   = bus.req_data[winner*WIDTH +: WIDTH];
          grant_next  = winner;
          rr_ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          state_next  = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.out_ready) begin
          if (HOLD == 0) begin
            state_next = IDLE;
          end else begin
            cnt_next   = 4'(HOLD - 1);
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      cnt_reg    <= 4'd0;
      data_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      cnt_reg    <= cnt_next;
      data_reg   <= data_next;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.out_data  = data_reg;
  assign bus.out_valid = (state_reg == DRIVE);
  assign bus.grant_id  = grant_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_ixc_assign_sched.sv
// Directed bench for ixc_assign_sched. It uses three builds: HOLD=2 (table plus stall),
// HOLD=0 (back-to-back throughput) and HOLD=15 (long settle).
module tb_ixc_assign_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ixc_assign_sched_if #(.WIDTH(29), .NREQ(4)) ia ();
  ixc_assign_sched_if #(.WIDTH(29), .NREQ(4)) ib ();
  ixc_assign_sched_if #(.WIDTH(29), .NREQ(4)) ic ();

  ixc_assign_sched #(.WIDTH(29), .NREQ(4), .HOLD(2))  dut_a (.clk(clk), .rst(rst), .bus(ia));
  ixc_assign_sched #(.WIDTH(29), .NREQ(4), .HOLD(0))  dut_b (.clk(clk), .rst(rst), .bus(ib));
  ixc_assign_sched #(.WIDTH(29), .NREQ(4), .HOLD(15)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       ordy;
    logic [3:0] rr;
    logic       ov;
    logic [1:0] gid;
    int         didx;
    logic       busy;
  } vec_t;

  vec_t        tbl[$];
  logic [28:0] dv[4];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rv, input logic ordy, input logic [3:0] rr,
                     input logic ov, input logic [1:0] gid, input int didx, input logic busy);
    vec_t v;
    v.rst = r; v.rv = rv; v.ordy = ordy; v.rr = rr;
    v.ov = ov; v.gid = gid; v.didx = didx; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] exp_data(input int didx);
    return (didx < 0) ? 29'd0 : dv[didx];
  endfunction

  initial begin
    int first;
    dv[0] = 29'h0123456; dv[1] = 29'h0BEEF01; dv[2] = 29'h1ABCDEF; dv[3] = 29'h1F0F0F0;
    rst = 1'b1;
    ia.req_valid = '0; ia.out_ready = 1'b0; ia.req_data = {dv[3], dv[2], dv[1], dv[0]};
    ib.req_valid = '0; ib.out_ready = 1'b1; ib.req_data = {dv[3], dv[2], dv[1], dv[0]};
    ic.req_valid = '0; ic.out_ready = 1'b0; ic.req_data = {dv[3], dv[2], dv[1], dv[0]};

    // Columns: rst, req_valid, out_ready | expected req_ready, out_valid, grant_id, data index, busy
    add(0, 4'b0000, 0, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b0100, 0, 4'b0100, 0, 0, -1, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 2,  2, 1);
    add(0, 4'b1111, 0, 4'b0000, 1, 2,  2, 1);
    add(0, 4'b1111, 1, 4'b0000, 1, 2,  2, 1);
    add(0, 4'b1111, 1, 4'b0000, 0, 2,  2, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 2,  2, 1);
    add(0, 4'b1111, 0, 4'b1000, 0, 2,  2, 0);
    add(0, 4'b1111, 1, 4'b0000, 1, 3,  3, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 3,  3, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 3,  3, 1);
    add(0, 4'b1111, 0, 4'b0001, 0, 3,  3, 0);
    add(0, 4'b1111, 1, 4'b0000, 1, 0,  0, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 0,  0, 1);
    add(0, 4'b1111, 0, 4'b0000, 0, 0,  0, 1);
    add(0, 4'b1111, 0, 4'b0010, 0, 0,  0, 0);
    add(0, 4'b0000, 1, 4'b0000, 1, 1,  1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,  1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,  1, 1);
    add(0, 4'b0100, 0, 4'b0100, 0, 1,  1, 0);
    add(0, 4'b1001, 1, 4'b0000, 1, 2,  2, 1);
    add(0, 4'b1001, 0, 4'b0000, 0, 2,  2, 1);
    add(0, 4'b0001, 0, 4'b0000, 0, 2,  2, 1);
    add(0, 4'b0001, 0, 4'b0001, 0, 2,  2, 0);
    add(0, 4'b0011, 0, 4'b0000, 1, 0,  0, 1);
    add(0, 4'b0011, 1, 4'b0000, 1, 0,  0, 1);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,  0, 1);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,  0, 1);
    add(0, 4'b0011, 0, 4'b0010, 0, 0,  0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 1,  1, 1);
    add(1, 4'b1111, 0, 4'b0000, 1, 1,  1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 0, -1, 0);
    add(0, 4'b1111, 0, 4'b0000, 1, 0,  0, 1);

    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      ia.req_valid = tbl[i].rv;
      ia.out_ready = tbl[i].ordy;
      @(negedge clk);
      $display("row %0d rst=%b rv=%b rr=%b ov=%b gid=%0d data=%h busy=%b", i, tbl[i].rst,
               tbl[i].rv, ia.req_ready, ia.out_valid, ia.grant_id, ia.out_data, ia.busy);
      check("req_ready", i, ia.req_ready, tbl[i].rr);
      check("out_valid", i, ia.out_valid, tbl[i].ov);
      check("grant_id",  i, ia.grant_id,  tbl[i].gid);
      check("out_data",  i, ia.out_data,  exp_data(tbl[i].didx));
      check("busy",      i, ia.busy,      tbl[i].busy);
      tick();
    end
    rst = 1'b0;

    // Consumer stall: requester 0's word is held while out_ready stays low.
    ia.req_valid = 4'b1111;
    ia.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      $display("stall %0d ov=%b data=%h rr=%b", c, ia.out_valid, ia.out_data, ia.req_ready);
      check("stall_ov",   c, ia.out_valid, 1'b1);
      check("stall_data", c, ia.out_data,  dv[0]);
      check("stall_rr",   c, ia.req_ready, 4'b0000);
      tick();
    end
    ia.out_ready = 1'b1;
    @(negedge clk);
    check("hs_rr", 0, ia.req_ready, 4'b0000);
    tick();
    ia.out_ready = 1'b0;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (first < 0 && ia.req_ready != 4'b0000) begin
        first = c;
        $display("regrant after %0d cycles rr=%b", c, ia.req_ready);
        check("regrant_rr", c, ia.req_ready, 4'b0010);
      end
      tick();
    end
    check("regrant_gap", 0, first, 3);

    // HOLD=0, with all requesters active and out_ready tied high, gives one grant every 2 cycles.
    ib.req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] er;
      @(negedge clk);
      er = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
      $display("b2b %0d rr=%b ov=%b gid=%0d", k, ib.req_ready, ib.out_valid, ib.grant_id);
      check("b2b_rr", k, ib.req_ready, er);
      check("b2b_ov", k, ib.out_valid, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k % 2 == 1) check("b2b_gid", k, ib.grant_id, ((k - 1) / 2) % 4);
      tick();
    end
    ib.req_valid = 4'b0000;

    // HOLD=15: busy stays high for exactly 15 cycles after the handshake.
    ic.req_valid = 4'b0100;
    ic.out_ready = 1'b1;
    @(negedge clk);
    check("h15_accept", 0, ic.req_ready, 4'b0100);
    tick();
    ic.req_valid = 4'b0000;
    @(negedge clk);
    check("h15_drive", 1, ic.out_valid, 1'b1);
    check("h15_gid",   1, ic.grant_id, 2);
    tick();
    ic.out_ready = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk);
      $display("h15 %0d busy=%b ov=%b data=%h", c, ic.busy, ic.out_valid, ic.out_data);
      check("h15_busy", c, ic.busy, (c <= 16) ? 1'b1 : 1'b0);
      check("h15_ov",   c, ic.out_valid, 1'b0);
      check("h15_data", c, ic.out_data, dv[2]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ixc_assign_sched.md
# ixc_assign_sched

Round-robin scheduler that shares one 29-bit static assignment path (an `ixc_assign_29` instance in the IXCOM template library) between several requesters. Each accepted request's word is latched into a hold register that drives the assign cell's `R` input, so `L` follows the held word. The block presents the word to a single consumer with a valid/ready handshake. After the handshake it enforces a programmable settle interval before it grants the next requester.

## Interface

Parameters:

- WIDTH, 29, data width; matches the shared assign cell.
- NREQ, 4, number of requesters, 2..8.
- HOLD, 2, settle cycles after consumer handshake before next grant, 0..15.

Ports:

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_data  in  NREQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot; high only in the acceptance cycle for the winner.
- out_data  out  WIDTH  hold register; drives R of the shared assign cell.
- out_valid  out  1  held word awaiting consumer.
- out_ready  in  1  consumer accepts held word.
- grant_id  out  $clog2(NREQ)  index of requester whose word is in out_data.
- busy  out  1  high in any state other than IDLE.

## Operation

- The FSM has three states: IDLE, DRIVE and SETTLE.
- **IDLE:**
  - If any req_valid is high, select the winner: the first set bit searching upward from rr_ptr, wrapping at NREQ-1 to 0.
  - Drive req_ready[winner]=1 combinationally in the same cycle; this cycle is the transfer.
  - Next edge: out_data<=req_data slice, grant_id<=winner, rr_ptr<=(winner+1) mod NREQ, state<=DRIVE.
  - With no request, stay in IDLE; req_ready=0.
- **DRIVE:**
  - out_valid=1 and req_ready=0.
  - On out_ready=1: if HOLD=0, go to IDLE; else load cnt<=HOLD-1 and go to SETTLE.
- **SETTLE:**
  - out_valid=0.
  - If cnt==0, go to IDLE; else decrement cnt.
- out_data and grant_id are not cleared after the handshake. They hold the last word, so the assign output stays static until the next acceptance.
- req_data is sampled only in the acceptance cycle. A requester may drop req_valid before it is granted; no request state is kept.
- Requests that arrive during DRIVE or SETTLE wait and are arbitrated on re-entry to IDLE.
- busy=(state!=IDLE).

## Timing

- **Reset values:** state=IDLE, rr_ptr=0, cnt=0, out_data=0, out_valid=0, req_ready=0, grant_id=0, busy=0.
- **Reset priority:** rst=1 overrides all transitions on that edge. A word captured or in DRIVE is discarded with no handshake, and out_data returns to 0.
- **Acceptance latency:** a request accepted at cycle N gives out_valid=1 and out_data valid at N+1.
- **Next acceptance:** with the handshake at cycle M (DRIVE and out_ready=1), out_valid=0 at M+1 and the next acceptance is earliest at M+1+HOLD.
- **Back-to-back throughput:** with HOLD=0 and out_ready tied high, one word every 2 cycles.
- **out_ready outside DRIVE** is ignored.
- **Simultaneous requests:** exactly one winner per acceptance. Every other requester is served within NREQ grants (starvation-free).
- **Pointer wrap:** winner NREQ-1 sets rr_ptr=0.
- **Combinational paths:** req_ready depends combinationally on req_valid, state and rr_ptr only. No combinational path from out_ready to req_ready.

## Test plan

- **Reset then single request:** rst for 2 cycles, then req_valid=4'b0100 with data 29'h1ABCDEF at cycle 5.
  - req_ready=4'b0100 at 5.
  - out_valid=1, out_data=29'h1ABCDEF, grant_id=2 at 6.
  - out_ready at 8 gives out_valid=0 at 9, IDLE at 11 (HOLD=2).
- **All four requesting continuously, out_ready tied high, HOLD=0:** grant order 0,1,2,3,0, one acceptance every 2 cycles, and each req_ready is one-hot.
- **Consumer stall:** out_ready held low for 20 cycles with requests pending. out_valid and out_data stay stable, req_ready stays 0 throughout, and the next grant comes HOLD+1 cycles after out_ready rises.
- **Request withdrawal and wrap:** rr_ptr=3, req_valid=4'b1001, then requester 3 drops req_valid one cycle before IDLE. Requester 0 wins and rr_ptr becomes 1.
- **Reset mid-DRIVE:** assert rst while out_valid=1. Next cycle out_valid=0, out_data=0, grant_id=0, busy=0, and no req_ready pulse in the same cycle.
- **HOLD=15 build:** busy stays high for exactly 15 cycles after the handshake cycle, with out_valid=0 and the last out_data retained.
